hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard controller sequencing the register-file/immediate/ALU datapath in the 5-stage pipe.
//  Tracks the destination register of the instructions in EX, MEM and WB in a 3-slot scoreboard.
//  Per cycle it issues stall/flush/bubble controls and operand-forwarding selects.
//  Sits beside the ID/EX pipeline registers; one instance per core.
// PARAMETERS
//  REG_AW   5   register-index width (32 architectural regs, x0 hardwired zero)
//  FWD_W    2   width of forwarding-select outputs
// PORTS
//  clk            in   1    pipeline clock; all state updates on posedge
//  rst_n          in   1    asynchronous, active-low reset
//  id_valid       in   1    ID stage holds a real instruction
//  id_ins         in   32   ID instruction: rs1=[19:15], rs2=[24:20], rd=[11:7]
//  id_use_rs1     in   1    ID instruction reads rs1
//  id_use_rs2     in   1    ID instruction reads rs2
//  id_regwen      in   1    ID instruction writes rd
//  id_is_load     in   1    ID instruction is a load (result available only at WB)
//  ex_br_taken    in   1    branch/jump in EX resolved taken (redirect)
//  mem_ready      in   1    data memory accepts/returns this cycle; 0 freezes the whole pipe
//  stall_if       out  1    hold PC and IF/ID register
//  stall_id       out  1    hold ID/EX inputs; EX receives a bubble instead
//  flush_id       out  1    kill the instruction in IF/ID (becomes NOP)
//  bubble_ex      out  1    load NOP into ID/EX this edge
//  fwd_a          out  2    EX operand A select: 00 regfile, 01 MEM alu_res, 10 WB data_in
//  fwd_b          out  2    EX operand B select, same encoding
//  id_byp_a       out  1    ID rs1 read takes WB data_in (same-cycle write/read)
//  id_byp_b       out  1    ID rs2 read takes WB data_in
// BEHAVIOUR
//  - Reset: all slots invalid (wen=0, rd=0, load=0); all outputs 0 while and after reset until ID input is valid.
//  - Slot: {wen, rd, load, rs1, rs2}. A slot with rd==0 never matches (x0 writes are ignored).
//  - Advance (posedge, mem_ready=1): WB<=MEM, MEM<=EX, EX<=ID fields or a bubble.
//    EX gets a bubble when bubble_ex=1 or id_valid=0.
//  - mem_ready=0: scoreboard frozen; stall_if=stall_id=1; flush_id=bubble_ex=0; fwd outputs still valid.
//  - Priority, highest first: mem freeze > ex_br_taken > load-use/RAW stall.
//  - Redirect (ex_br_taken=1, mem_ready=1): flush_id=1, bubble_ex=1, stall_if=0.
//    The ID instruction is discarded, so no stall is raised for it.
//  - Load-use: EX slot is a load with rd matching a used ID rs -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle.
//    The consumer then reaches EX with the load in WB -> fwd=10.
//  - fwd_x (combinational from EX slot vs MEM/WB slots): MEM match with non-load -> 01; else WB match -> 10; else 00.
//    A MEM match wins over a WB match (youngest value).
//  - id_byp_x=1 when the WB slot matches a used ID rs; covers the write-at-edge/async-read window of the regfile.
//  - All outputs combinational from slots + ID inputs: zero-cycle latency. Stall decision never depends on fwd outputs.
//  - Reset asserted mid-stall or mid-flush: slots cleared at once; no stale bubble survives reset.
// CONFIGURATION
//  HAZARD_FORWARDING_EN defined: forwarding as above; only load-use stalls.
//  HAZARD_FORWARDING_EN undefined: fwd_a=fwd_b=00 constantly.
//    Any used ID rs matching a valid EX or MEM slot stalls (bubble_ex=1) until the producer reaches WB.
//    Latency is up to 2 cycles. id_byp still active.
// STRUCTURE
//  Shared package riscv_pipe_pkg holds the following:
//    - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
//    - REG_AW
//    - hz_slot_t struct {wen, rd, load, rs1, rs2}
//    - function rd_match(slot, rs, use) (rd!=0 check)
//  Sub-module hazard_scoreboard: 3-slot shift register with freeze/bubble inputs; hazard_ctrl holds compare/priority logic.
// TESTING
//  1 reset: rst_n=0 with id_valid=1, rs1=x5 -> all outputs 0; after release, slots empty, no stall.
//  2 ALU RAW: add x5 then add x6,x5,x1 next cycle -> consumer in EX sees fwd_a=01; x5 two back -> fwd_a=10.
//  3 load-use: lw x7 then add x8,x7,x7 -> stall_if=stall_id=bubble_ex=1 one cycle, then fwd_a=fwd_b=10.
//  4 redirect: ex_br_taken=1 while ID holds lw-dependent add -> flush_id=1, bubble_ex=1, stall_if=0, no load-use stall.
//  5 freeze: mem_ready=0 for 3 cycles mid RAW -> slots unchanged, stall_if=1; fwd held; resumes identically.
//  6 x0 / WB window: write x0 then read x0 -> no stall, fwd=00. WB writing x9 while ID reads x9 -> id_byp_a=1.
//    Repeat 2-3 with HAZARD_FORWARDING_EN undefined -> 2-cycle and 2-cycle stalls, fwd=00.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the hazard controller: forwarding-select
// encodings, register-index width, the scoreboard slot layout and the
// destination-match helper used by every hazard comparison.
package riscv_pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // operand from MEM-stage ALU result
  localparam logic [1:0] FWD_WB  = 2'b10;  // operand from WB-stage write data

  typedef struct packed {
    logic              wen;
    logic [REG_AW-1:0] rd;
    logic              load;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } hz_slot_t;

  localparam hz_slot_t HZ_SLOT_EMPTY = '{
    wen:  1'b0,
    rd:   {REG_AW{1'b0}},
    load: 1'b0,
    rs1:  {REG_AW{1'b0}},
    rs2:  {REG_AW{1'b0}}
  };

  // True when the slot produces a value the given source register needs.
  // Writes to x0 are discarded by the register file, so they never match.
  function automatic logic rd_match(input hz_slot_t slot,
                                    input logic [REG_AW-1:0] rs,
                                    input logic use_rs);
    return use_rs & slot.wen & (slot.rd != {REG_AW{1'b0}}) & (slot.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-slot destination scoreboard mirroring the EX, MEM and WB stages.
// Shifts one stage per cycle when the pipe advances; a bubble loads an empty
// slot into EX. Holds every slot while the pipe is frozen.
module hazard_scoreboard
  import riscv_pipe_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     advance,
  input  logic     bubble,
  input  hz_slot_t id_slot,
  output hz_slot_t ex_slot,
  output hz_slot_t mem_slot,
  output hz_slot_t wb_slot
);

  hz_slot_t ex_r;
  hz_slot_t mem_r;
  hz_slot_t wb_r;

  // Stage shift: WB<=MEM, MEM<=EX, EX<=ID or bubble; frozen when not advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r  <= HZ_SLOT_EMPTY;
      mem_r <= HZ_SLOT_EMPTY;
      wb_r  <= HZ_SLOT_EMPTY;
    end else if (advance) begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      ex_r  <= bubble ? HZ_SLOT_EMPTY : id_slot;
    end else begin
      wb_r  <= wb_r;
      mem_r <= mem_r;
      ex_r  <= ex_r;
    end
  end

  assign ex_slot  = ex_r;
  assign mem_slot = mem_r;
  assign wb_slot  = wb_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipe: compares the ID instruction's
// sources against the EX/MEM/WB scoreboard and issues stall, flush, bubble,
// EX forwarding selects and ID write-through bypass. All outputs are
// combinational from the scoreboard and the current ID inputs.
// Build option: define HAZARD_FORWARDING_EN to enable EX operand forwarding
// (only load-use stalls). Without it forwarding selects stay at the register
// file and any RAW against EX or MEM stalls until the producer reaches WB.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int FWD_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_ins,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_regwen,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             id_byp_a,
  output logic             id_byp_b
);

  logic [REG_AW-1:0] id_rs1_s;
  logic [REG_AW-1:0] id_rs2_s;
  logic [REG_AW-1:0] id_rd_s;
  hz_slot_t          id_slot_s;
  hz_slot_t          ex_s;
  hz_slot_t          mem_s;
  hz_slot_t          wb_s;
  logic              hz_raw_s;
  logic              sb_bubble_s;
  logic              stall_if_s;
  logic              stall_id_s;
  logic              flush_id_s;
  logic              bubble_ex_s;
  logic [1:0]        fwd_a_s;
  logic [1:0]        fwd_b_s;
  logic              id_byp_a_s;
  logic              id_byp_b_s;
  logic              unused_s;

  assign id_rs1_s = id_ins[19:15];
  assign id_rs2_s = id_ins[24:20];
  assign id_rd_s  = id_ins[11:7];

  // Bits outside the register fields and slot fields not consumed in this build.
  assign unused_s = ^{id_ins, ex_s, mem_s, wb_s};

`ifdef HAZARD_FORWARDING_EN
  // Youngest value wins: MEM ALU result, then WB data, else register file.
  // A load in MEM has no data yet, so it cannot be forwarded from there.
  function automatic logic [1:0] fwd_sel(input hz_slot_t mem_slot,
                                         input hz_slot_t wb_slot,
                                         input logic [REG_AW-1:0] rs);
    if (rd_match(mem_slot, rs, 1'b1) && !mem_slot.load) begin
      return FWD_MEM;
    end else if (rd_match(wb_slot, rs, 1'b1)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction
`endif

  // Pack the ID instruction into a scoreboard slot for the next EX entry.
  always_comb begin
    id_slot_s      = HZ_SLOT_EMPTY;
    id_slot_s.wen  = id_regwen;
    id_slot_s.rd   = id_rd_s;
    id_slot_s.load = id_is_load;
    id_slot_s.rs1  = id_rs1_s;
    id_slot_s.rs2  = id_rs2_s;
  end

  // RAW detection against older in-flight producers of a used ID source.
  always_comb begin
    hz_raw_s = 1'b0;
    if (id_valid) begin
`ifdef HAZARD_FORWARDING_EN
      hz_raw_s = ex_s.load & (rd_match(ex_s, id_rs1_s, id_use_rs1) |
                              rd_match(ex_s, id_rs2_s, id_use_rs2));
`else
      hz_raw_s = rd_match(ex_s,  id_rs1_s, id_use_rs1) |
                 rd_match(ex_s,  id_rs2_s, id_use_rs2) |
                 rd_match(mem_s, id_rs1_s, id_use_rs1) |
                 rd_match(mem_s, id_rs2_s, id_use_rs2);
`endif
    end else begin
      hz_raw_s = 1'b0;
    end
  end

  // Pipe control priority: memory freeze, then redirect, then RAW stall.
  always_comb begin
    stall_if_s  = 1'b0;
    stall_id_s  = 1'b0;
    flush_id_s  = 1'b0;
    bubble_ex_s = 1'b0;
    if (!rst_n) begin
      stall_if_s  = 1'b0;
      stall_id_s  = 1'b0;
    end else if (!mem_ready) begin
      stall_if_s  = 1'b1;
      stall_id_s  = 1'b1;
    end else if (ex_br_taken) begin
      flush_id_s  = 1'b1;
      bubble_ex_s = 1'b1;
    end else if (hz_raw_s) begin
      stall_if_s  = 1'b1;
      stall_id_s  = 1'b1;
      bubble_ex_s = 1'b1;
    end else begin
      bubble_ex_s = 1'b0;
    end
  end

  // EX forwarding selects and ID write-through bypass from scoreboard matches.
  always_comb begin
    fwd_a_s    = FWD_RF;
    fwd_b_s    = FWD_RF;
    id_byp_a_s = 1'b0;
    id_byp_b_s = 1'b0;
    if (rst_n) begin
`ifdef HAZARD_FORWARDING_EN
      fwd_a_s = fwd_sel(mem_s, wb_s, ex_s.rs1);
      fwd_b_s = fwd_sel(mem_s, wb_s, ex_s.rs2);
`endif
      id_byp_a_s = id_valid & rd_match(wb_s, id_rs1_s, id_use_rs1);
      id_byp_b_s = id_valid & rd_match(wb_s, id_rs2_s, id_use_rs2);
    end else begin
      fwd_a_s    = FWD_RF;
      fwd_b_s    = FWD_RF;
    end
  end

  assign sb_bubble_s = bubble_ex_s | ~id_valid;

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (mem_ready),
    .bubble   (sb_bubble_s),
    .id_slot  (id_slot_s),
    .ex_slot  (ex_s),
    .mem_slot (mem_s),
    .wb_slot  (wb_s)
  );

  assign stall_if  = stall_if_s;
  assign stall_id  = stall_id_s;
  assign flush_id  = flush_id_s;
  assign bubble_ex = bubble_ex_s;
  assign fwd_a     = FWD_W'(fwd_a_s);
  assign fwd_b     = FWD_W'(fwd_b_s);
  assign id_byp_a  = id_byp_a_s;
  assign id_byp_b  = id_byp_b_s;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios per feature plus a randomized
// run checked against an in-flight instruction model (queue of EX/MEM/WB).
// Expectations follow the HAZARD_FORWARDING_EN build option.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_ins;
  logic        id_use_rs1, id_use_rs2, id_regwen, id_is_load;
  logic        ex_br_taken, mem_ready;
  logic        stall_if, stall_id, flush_id, bubble_ex;
  logic [1:0]  fwd_a, fwd_b;
  logic        id_byp_a, id_byp_b;

  int nchk = 0;
  int nerr = 0;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ins(id_ins),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_regwen(id_regwen),
    .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .bubble_ex(bubble_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_byp_a(id_byp_a), .id_byp_b(id_byp_b)
  );

  // ---------------- reference model: instructions in flight ----------------
  typedef struct {bit wr; int rd; bit ld; int s1; int s2;} ins_t;
  ins_t pipe[$];  // [0]=EX, [1]=MEM, [2]=WB
  bit e_si, e_sd, e_fl, e_bx, e_ba, e_bb;
  int e_fa, e_fb;

  function automatic bit wr_hit(ins_t p, int r);
    return p.wr && p.rd != 0 && p.rd == r;
  endfunction

  function automatic int fsel(int r);
    if (wr_hit(pipe[1], r) && !pipe[1].ld) return 1;
    if (wr_hit(pipe[2], r)) return 2;
    return 0;
  endfunction

  task automatic model_reset;
    ins_t n = '{default: 0};
    pipe = {};
    repeat (3) pipe.push_back(n);
  endtask

  task automatic model_eval;
    int r1, r2; bit hz;
    r1 = id_use_rs1 ? int'(id_ins[19:15]) : 0;
    r2 = id_use_rs2 ? int'(id_ins[24:20]) : 0;
    hz = 1'b0;
    if (id_valid)
      for (int s = 0; s < 2; s++)
        if (wr_hit(pipe[s], r1) || wr_hit(pipe[s], r2))
          if (!FWD_ON || (s == 0 && pipe[0].ld)) hz = 1'b1;
    e_fa = FWD_ON ? fsel(pipe[0].s1) : 0;
    e_fb = FWD_ON ? fsel(pipe[0].s2) : 0;
    e_ba = id_valid && wr_hit(pipe[2], r1);
    e_bb = id_valid && wr_hit(pipe[2], r2);
    if (!mem_ready)       {e_si, e_sd, e_fl, e_bx} = 4'b1100;
    else if (ex_br_taken) {e_si, e_sd, e_fl, e_bx} = 4'b0011;
    else if (hz)          {e_si, e_sd, e_fl, e_bx} = 4'b1101;
    else                  {e_si, e_sd, e_fl, e_bx} = 4'b0000;
    if (!rst_n) begin
      {e_si, e_sd, e_fl, e_bx, e_ba, e_bb} = 6'b0;
      e_fa = 0; e_fb = 0;
    end
  endtask

  task automatic model_step;
    ins_t n = '{default: 0};
    if (!rst_n) model_reset();
    else if (mem_ready) begin
      if (!(e_bx || !id_valid))
        n = '{wr: id_regwen, rd: int'(id_ins[11:7]), ld: id_is_load,
              s1: int'(id_ins[19:15]), s2: int'(id_ins[24:20])};
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    model_eval();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_id(input int rd, input int rs1, input int rs2, input bit v,
                        input bit u1, input bit u2, input bit w, input bit ld);
    id_ins = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    id_valid = v; id_use_rs1 = u1; id_use_rs2 = u2; id_regwen = w; id_is_load = ld;
    #1;
  endtask

  task automatic drain(input int n);
    ex_br_taken = 1'b0; mem_ready = 1'b1;
    set_id(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; ex_br_taken = 1'b0; mem_ready = 1'b1;
    model_reset();
    set_id(0, 5, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    nchk++; if ({stall_if, stall_id, flush_id, bubble_ex} !== 4'b0000) begin nerr++; $display("FAIL rst_ctrl got %b exp 0000", {stall_if, stall_id, flush_id, bubble_ex}); end
    nchk++; if ({fwd_a, fwd_b} !== 4'b0000) begin nerr++; $display("FAIL rst_fwd got %b exp 0000", {fwd_a, fwd_b}); end
    nchk++; if ({id_byp_a, id_byp_b} !== 2'b00) begin nerr++; $display("FAIL rst_byp got %b exp 00", {id_byp_a, id_byp_b}); end
    rst_n = 1'b1;
    #1;
    nchk++; if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin nerr++; $display("FAIL rst_release_stall got %b exp 000", {stall_if, stall_id, bubble_ex}); end
    tick();
    nchk++; if ({fwd_a, id_byp_a, stall_id} !== 4'b0000) begin nerr++; $display("FAIL rst_after_edge got %b exp 0000", {fwd_a, id_byp_a, stall_id}); end
  endtask

  task automatic test_alu_raw;
    int n;
    drain(3);
    set_id(5, 1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    set_id(6, 5, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n = 0; while (stall_id === 1'b1 && n < 8) begin n++; tick(); end
    nchk++; if (n !== (FWD_ON ? 0 : 2)) begin nerr++; $display("FAIL raw1_stall_cycles got %0d exp %0d", n, FWD_ON ? 0 : 2); end
`ifndef HAZARD_FORWARDING_EN
    nchk++; if (id_byp_a !== 1'b1) begin nerr++; $display("FAIL raw1_byp got %b exp 1", id_byp_a); end
`endif
    tick();
    set_id(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nchk++; if (fwd_a !== (FWD_ON ? 2'b01 : 2'b00)) begin nerr++; $display("FAIL raw1_fwd_a got %b exp %b", fwd_a, FWD_ON ? 2'b01 : 2'b00); end
    nchk++; if (fwd_b !== 2'b00) begin nerr++; $display("FAIL raw1_fwd_b got %b exp 00", fwd_b); end
    drain(3);
    set_id(5, 1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    set_id(10, 3, 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    set_id(6, 5, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n = 0; while (stall_id === 1'b1 && n < 8) begin n++; tick(); end
    nchk++; if (n !== (FWD_ON ? 0 : 1)) begin nerr++; $display("FAIL raw2_stall_cycles got %0d exp %0d", n, FWD_ON ? 0 : 1); end
    tick();
    set_id(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nchk++; if (fwd_a !== (FWD_ON ? 2'b10 : 2'b00)) begin nerr++; $display("FAIL raw2_fwd_a got %b exp %b", fwd_a, FWD_ON ? 2'b10 : 2'b00); end
  endtask

  task automatic test_load_use;
    int n;
    drain(3);
    set_id(7, 1, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    set_id(8, 7, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    nchk++; if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b1110) begin nerr++; $display("FAIL lu_ctrl got %b exp 1110", {stall_if, stall_id, bubble_ex, flush_id}); end
    n = 0; while (stall_id === 1'b1 && n < 8) begin n++; tick(); end
    nchk++; if (n !== (FWD_ON ? 1 : 2)) begin nerr++; $display("FAIL lu_stall_cycles got %0d exp %0d", n, FWD_ON ? 1 : 2); end
    nchk++; if ({id_byp_a, id_byp_b} !== (FWD_ON ? 2'b00 : 2'b11)) begin nerr++; $display("FAIL lu_byp got %b exp %b", {id_byp_a, id_byp_b}, FWD_ON ? 2'b00 : 2'b11); end
    tick();
    set_id(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nchk++; if ({fwd_a, fwd_b} !== (FWD_ON ? 4'b1010 : 4'b0000)) begin nerr++; $display("FAIL lu_fwd got %b exp %b", {fwd_a, fwd_b}, FWD_ON ? 4'b1010 : 4'b0000); end
  endtask

  task automatic test_redirect;
    drain(3);
    set_id(7, 1, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    ex_br_taken = 1'b1;
    set_id(8, 7, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    nchk++; if ({flush_id, bubble_ex, stall_if, stall_id} !== 4'b1100) begin nerr++; $display("FAIL redir_ctrl got %b exp 1100", {flush_id, bubble_ex, stall_if, stall_id}); end
    tick();
    ex_br_taken = 1'b0;
    set_id(9, 8, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    nchk++; if (stall_id !== 1'b0) begin nerr++; $display("FAIL redir_killed_stall got %b exp 0", stall_id); end
    tick();
    nchk++; if (fwd_a !== 2'b00) begin nerr++; $display("FAIL redir_killed_fwd got %b exp 00", fwd_a); end
  endtask

  task automatic test_freeze;
    int n; logic [1:0] efa;
    drain(3);
    set_id(5, 1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    set_id(6, 5, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef HAZARD_FORWARDING_EN
    tick();
    set_id(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    efa = 2'b01;
`else
    efa = 2'b00;
`endif
    mem_ready = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      nchk++; if ({stall_if, stall_id, flush_id, bubble_ex} !== 4'b1100) begin nerr++; $display("FAIL frz_ctrl[%0d] got %b exp 1100", c, {stall_if, stall_id, flush_id, bubble_ex}); end
      nchk++; if (fwd_a !== efa) begin nerr++; $display("FAIL frz_fwd[%0d] got %b exp %b", c, fwd_a, efa); end
      tick();
    end
    mem_ready = 1'b1; #1;
    nchk++; if (fwd_a !== efa) begin nerr++; $display("FAIL frz_resume_fwd got %b exp %b", fwd_a, efa); end
    n = 0; while (stall_id === 1'b1 && n < 8) begin n++; tick(); end
    nchk++; if (n !== (FWD_ON ? 0 : 2)) begin nerr++; $display("FAIL frz_resume_stall got %0d exp %0d", n, FWD_ON ? 0 : 2); end
  endtask

  task automatic test_x0_wb_window;
    drain(3);
    set_id(0, 1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    set_id(3, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    nchk++; if (stall_id !== 1'b0) begin nerr++; $display("FAIL x0_stall got %b exp 0", stall_id); end
    tick();
    set_id(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    nchk++; if ({fwd_a, fwd_b} !== 4'b0000) begin nerr++; $display("FAIL x0_fwd got %b exp 0000", {fwd_a, fwd_b}); end
    drain(3);
    set_id(9, 1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drain(2);
    set_id(10, 9, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    nchk++; if ({id_byp_a, id_byp_b, stall_id} !== 3'b100) begin nerr++; $display("FAIL wb_byp got %b exp 100", {id_byp_a, id_byp_b, stall_id}); end
    set_id(10, 9, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    nchk++; if (id_byp_a !== 1'b0) begin nerr++; $display("FAIL wb_byp_unused got %b exp 0", id_byp_a); end
  endtask

  task automatic test_reset_mid_stall;
    drain(3);
    set_id(7, 1, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    set_id(8, 7, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    nchk++; if (stall_id !== 1'b1) begin nerr++; $display("FAIL rstmid_pre got %b exp 1", stall_id); end
    rst_n = 1'b0; model_reset(); #1;
    nchk++; if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin nerr++; $display("FAIL rstmid_during got %b exp 000", {stall_if, stall_id, bubble_ex}); end
    @(negedge clk); rst_n = 1'b1; #1;
    nchk++; if ({stall_id, bubble_ex} !== 2'b00) begin nerr++; $display("FAIL rstmid_release got %b exp 00", {stall_id, bubble_ex}); end
    tick();
    nchk++; if ({stall_id, fwd_a} !== 3'b000) begin nerr++; $display("FAIL rstmid_after got %b exp 000", {stall_id, fwd_a}); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 800; c++) begin
      ex_br_taken = ($urandom_range(0, 9) == 0);
      mem_ready   = ($urandom_range(0, 6) != 0);
      set_id(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      model_eval();
      nchk++; if (stall_if !== e_si) begin nerr++; $display("FAIL rnd_stall_if c=%0d got %b exp %b", c, stall_if, e_si); end
      nchk++; if (stall_id !== e_sd) begin nerr++; $display("FAIL rnd_stall_id c=%0d got %b exp %b", c, stall_id, e_sd); end
      nchk++; if (flush_id !== e_fl) begin nerr++; $display("FAIL rnd_flush_id c=%0d got %b exp %b", c, flush_id, e_fl); end
      nchk++; if (bubble_ex !== e_bx) begin nerr++; $display("FAIL rnd_bubble_ex c=%0d got %b exp %b", c, bubble_ex, e_bx); end
      nchk++; if (fwd_a !== 2'(e_fa)) begin nerr++; $display("FAIL rnd_fwd_a c=%0d got %b exp %0d", c, fwd_a, e_fa); end
      nchk++; if (fwd_b !== 2'(e_fb)) begin nerr++; $display("FAIL rnd_fwd_b c=%0d got %b exp %0d", c, fwd_b, e_fb); end
      nchk++; if (id_byp_a !== e_ba) begin nerr++; $display("FAIL rnd_byp_a c=%0d got %b exp %b", c, id_byp_a, e_ba); end
      nchk++; if (id_byp_b !== e_bb) begin nerr++; $display("FAIL rnd_byp_b c=%0d got %b exp %b", c, id_byp_b, e_bb); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_raw();
    test_load_use();
    test_redirect();
    test_freeze();
    test_x0_wb_window();
    test_reset_mid_stall();
    drain(3);
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
